fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  - Instruction fetch stage directly upstream of the control decoder.
//  - Owns the PC, issues req/ack reads to instruction memory, holds the result in an IF/ID register.
//  - Presents op [31:26] and funct [5:0] to control; applies branch/jump redirects.
//  - Single-entry skid buffer absorbs downstream stalls so no fetched word is lost.
// PARAMETERS
//  ADDR_W    32   PC / imem address width
//  RESET_PC  0    PC value loaded at reset (bits [1:0] ignored, forced 0)
// PORTS
//  clk             in   1       sole clock, rising edge
//  rst_n           in   1       reset: one clock; asynchronous, active-low
//  imem_req        out  1       read request; held high until imem_ack
//  imem_addr       out  ADDR_W  word-aligned read address; stable while imem_req=1
//  imem_ack        in   1       1-cycle pulse: imem_rdata valid; legal the same cycle as req rises
//  imem_rdata      in   32      instruction word
//  redirect_valid  in   1       1-cycle pulse: branch taken or jump
//  redirect_pc     in   ADDR_W  new PC; bits [1:0] forced to 0
//  id_ready        in   1       decode consumes if_instr this cycle when if_valid=1
//  if_valid        out  1       IF/ID register holds a live instruction
//  if_instr        out  32      instruction word
//  if_pc           out  ADDR_W  address of if_instr
//  if_op           out  6       if_instr[31:26], combinational from if_instr
//  if_funct        out  6       if_instr[5:0], combinational from if_instr
// BEHAVIOUR
//  - Reset values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, buffer empty, state=IDLE.
//  - States:
//    - IDLE: first cycle after rst_n rises -> REQ.
//    - REQ: imem_req=1, imem_addr=pc.
//      - On ack, if IF/ID is empty or being consumed: load IF/ID, pc<=pc+4, stay REQ.
//      - On ack otherwise: word goes to the skid buffer, pc<=pc+4 -> HOLD.
//    - HOLD: imem_req=0. When id_ready & if_valid: buffer moves to IF/ID -> REQ.
//    - DRAIN: imem_req stays 1 at the old address; the ack'd word is discarded -> REQ at the new pc.
//  - Throughput and latency:
//    - 1 instr/cycle when imem acks the same cycle as req and id_ready=1.
//    - IF/ID updates on the edge after ack; latency is 1 cycle from ack.
//  - pc+4 wraps modulo 2^ADDR_W; 0xFFFFFFFC -> 0x00000000, no flag.
//  - Redirect (any state except IDLE): pc<=redirect_pc, if_valid<=0, buffer cleared.
//    - Request outstanding, no ack this cycle -> DRAIN (addr must not change mid-request).
//    - Ack in the same cycle as redirect: the word is dropped -> REQ.
//    - Redirect in HOLD or DRAIN -> REQ, or stay DRAIN if the ack is still pending.
//    - Redirect beats id_ready: IF/ID is flushed even if consumed.
//  - rst_n low mid-request: all state clears immediately; a later stray ack is ignored in IDLE.
// CONFIGURATION
//  FETCH_STATS_EN defined:
//    - Adds out fetch_cnt [31:0]: counts instructions loaded into IF/ID.
//    - Adds out stall_cnt [31:0]: counts cycles with if_valid & !id_ready.
//    - Both reset to 0 and wrap at 2^32.
//  FETCH_STATS_EN undefined: both ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  - Shared package mips_pkg holds:
//    - INSTR_W=32 and the OP_*/FUNCT_* opcode constants shared with control;
//    - fetch_state_t enum {IDLE, REQ, HOLD, DRAIN}.
//  - One sub-module, fetch_skid_buf: 1-entry {instr, pc} buffer with load/pop/flush.
// TESTING
//  - Reset, RESET_PC=0x100, imem acks every cycle, id_ready=1:
//    - imem_addr 0x100,0x104,0x108;
//    - if_pc follows one cycle behind;
//    - if_op/if_funct match the words.
//  - Back-pressure: id_ready=0 for 3 cycles:
//    - exactly one extra word buffered, req drops in HOLD;
//    - on release, words arrive in order with no loss or duplication.
//  - Redirect to 0x2003 with req outstanding and ack delayed 2 cycles:
//    - stale word dropped;
//    - next imem_addr=0x2000;
//    - if_valid=0 until the new word arrives.
//  - Redirect coincident with ack: the acked word never appears; next fetch from redirect_pc.
//  - PC=0xFFFFFFFC: next imem_addr=0x00000000.
//  - rst_n pulsed low mid-request: outputs reset asynchronously; a pending ack after reset is ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: instruction width, opcode/funct constants shared with control, fetch FSM states.
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_JR  = 6'h08;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: req/ack instruction-memory read port between fetch and imem.
interface fetch_stage_if #(parameter int unsigned ADDR_W = 32) ();
  logic                       imem_req;
  logic [ADDR_W-1:0]          imem_addr;
  logic                       imem_ack;
  logic [mips_pkg::INSTR_W-1:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: single-entry {instr, pc} holding slot; flush wins over load, load over pop.
module fetch_skid_buf import mips_pkg::*; #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               pop,
  input  logic               flush,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else begin
      valid <= flush ? 1'b0 : load ? 1'b1 : pop ? 1'b0 : valid;
      if (load && !flush) begin
        instr <= in_instr;
        pc    <= in_pc;
      end
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, imem req/ack fetch, IF/ID register with skid buffer, redirects.
// Define FETCH_STATS_EN to add fetch_cnt/stall_cnt counters.
module fetch_stage import mips_pkg::*; #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_stage_if.master      imem,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [5:0]         if_op,
  output logic [5:0]         if_funct
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt
`endif
);
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC0   = RESET_PC & ALIGN;
  fetch_state_t state, state_n;
  logic [ADDR_W-1:0]  pc, drain_addr, buf_pc;
  logic [INSTR_W-1:0] buf_instr;
  logic buf_valid, ack, redir, consume, if_free, ld_mem, ld_skid, ld_buf;
  assign ack     = imem.imem_ack;
  assign redir   = redirect_valid && state != IDLE;
  assign consume = if_valid && id_ready;
  assign if_free = !if_valid || id_ready;
  assign ld_mem  = state == REQ && ack && if_free && !redir;
  assign ld_skid = state == REQ && ack && !if_free && !redir;
  assign ld_buf  = state == HOLD && consume && buf_valid && !redir;
  // DRAIN keeps presenting the abandoned address until its ack retires it.
  assign imem.imem_req  = state == REQ || state == DRAIN;
  assign imem.imem_addr = state == DRAIN ? drain_addr : pc;
  assign if_op    = if_instr[31:26];
  assign if_funct = if_instr[5:0];
  always_comb begin
    state_n = state == IDLE ? REQ
            : state == REQ  ? (redir ? (ack ? REQ : DRAIN) : (ack && !if_free ? HOLD : REQ))
            : state == HOLD ? (redir || consume ? REQ : HOLD)
            : (ack ? REQ : DRAIN);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= PC0;
      drain_addr <= PC0;
    end else begin
      state <= state_n;
      if (redir) pc <= redirect_pc & ALIGN;
      else if (state == REQ && ack) pc <= pc + ADDR_W'(4);
      if (state == REQ && redir && !ack) drain_addr <= pc;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (redir) begin
      if_valid <= 1'b0;
    end else if (ld_mem) begin
      if_valid <= 1'b1;
      if_instr <= imem.imem_rdata;
      if_pc    <= pc;
    end else if (ld_buf) begin
      if_valid <= 1'b1;
      if_instr <= buf_instr;
      if_pc    <= buf_pc;
    end else if (consume) begin
      if_valid <= 1'b0;
    end
  end
  fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld_skid),
    .pop      (ld_buf),
    .flush    (redir),
    .in_instr (imem.imem_rdata),
    .in_pc    (pc),
    .valid    (buf_valid),
    .instr    (buf_instr),
    .pc       (buf_pc)
  );
`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + 32'(ld_mem || ld_buf);
      stall_cnt <= stall_cnt + 32'(if_valid && !id_ready);
    end
  end
`endif
endmodule
